// File: rtl/serializer_pkg.sv
// Shared types and constants for the operand serializer slice.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
//
// Contents:
//   ser_state_t    - serializer control state (IDLE / SHIFT)
//   SER_WIDTH_DEF  - default operand width
//   ser_cnt_w()    - bit-counter width for a given operand width
package serializer_pkg;

    localparam int SER_WIDTH_DEF = 4;

    typedef enum logic {
        IDLE  = 1'b0,
        SHIFT = 1'b1
    } ser_state_t;

    // A 2-bit operand still needs a 1-bit counter; $clog2(1) would give 0.
    function automatic int ser_cnt_w(input int width);
        return (width > 2) ? $clog2(width) : 1;
    endfunction

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-in serial-out shift register; dout is always bit 0 of the register.
// Latency: load visible on dout the cycle after the load edge.
// Backpressure: none internally; the caller holds 'shift' low to freeze the register.
//
// Ports:
//   clk, reset    - clock, synchronous active-high reset (clears the register)
//   load, din     - parallel load (takes priority over shift)
//   shift         - shift right one place, zero-filling the MSB
//   dout          - current serial bit (register bit 0)
module piso_shift_reg #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             shift,
    input  logic [WIDTH-1:0] din,
    output logic             dout
);

    logic [WIDTH-1:0] r_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_data <= '0;
        end else if (load) begin
            r_data <= din;
        end else if (shift) begin
            r_data <= {1'b0, r_data[WIDTH-1:1]};
        end
    end

    assign dout = r_data[0];

endmodule

// File: rtl/operand_serializer.sv
// Serializes a pair of WIDTH-bit operands LSB-first with first/last markers.
// Latency: first bit pair valid the cycle after the accepting edge; WIDTH+1 cycles per pair unstalled.
// Backpressure: bit_ready low freezes state and outputs; in_ready is low for the whole stream.
//
// Ports:
//   clk, reset            - clock, synchronous active-high reset
//   in_valid/in_ready     - operand handshake, a/b sampled on the accepting edge only
//   a, b                  - WIDTH-bit unsigned operands
//   bit_valid/bit_ready   - serial bit-pair handshake
//   a_bit, b_bit          - current bit pair, LSB first
//   first, last           - bit pair is bit 0 / bit WIDTH-1
//   busy                  - a serialization is in progress
module operand_serializer
    import serializer_pkg::*;
#(
    parameter int WIDTH = SER_WIDTH_DEF
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             bit_valid,
    input  logic             bit_ready,
    output logic             a_bit,
    output logic             b_bit,
    output logic             first,
    output logic             last,
    output logic             busy
);

    localparam int              CW       = ser_cnt_w(WIDTH);
    localparam logic [CW-1:0]   CNT_LAST = CW'(WIDTH - 1);

    ser_state_t     r_state;
    ser_state_t     w_next_state;
    logic [CW-1:0]  r_count;

    logic           w_accept;
    logic           w_xfer;
    logic           w_at_last;
    logic           w_a_dout;
    logic           w_b_dout;

    // Handshake qualifiers are derived from registered state, so no output
    // below depends combinationally on any input.
    assign w_accept  = (r_state == IDLE)  && in_valid;
    assign w_xfer    = (r_state == SHIFT) && bit_ready;
    assign w_at_last = (r_count == CNT_LAST);

    // ------------------------------------------------------------------
    // Operand shift registers
    // ------------------------------------------------------------------
    piso_shift_reg #(.WIDTH(WIDTH)) u_sr_a (
        .clk   (clk),
        .reset (reset),
        .load  (w_accept),
        .shift (w_xfer),
        .din   (a),
        .dout  (w_a_dout)
    );

    piso_shift_reg #(.WIDTH(WIDTH)) u_sr_b (
        .clk   (clk),
        .reset (reset),
        .load  (w_accept),
        .shift (w_xfer),
        .din   (b),
        .dout  (w_b_dout)
    );

    // ------------------------------------------------------------------
    // FSM: state register
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // ------------------------------------------------------------------
    // FSM: next-state logic
    // ------------------------------------------------------------------
    always_comb begin
        w_next_state = r_state;
        unique case (r_state)
            IDLE: begin
                if (w_accept) begin
                    w_next_state = SHIFT;
                end
            end
            SHIFT: begin
                if (w_xfer && w_at_last) begin
                    w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    // ------------------------------------------------------------------
    // FSM: outputs
    // ------------------------------------------------------------------
    // Bit and marker outputs are gated by SHIFT so that idle cycles always
    // present zeros, regardless of what is left in the shift registers.
    always_comb begin
        in_ready  = 1'b0;
        bit_valid = 1'b0;
        a_bit     = 1'b0;
        b_bit     = 1'b0;
        first     = 1'b0;
        last      = 1'b0;
        busy      = 1'b0;
        unique case (r_state)
            IDLE: begin
                in_ready = 1'b1;
            end
            SHIFT: begin
                bit_valid = 1'b1;
                busy      = 1'b1;
                a_bit     = w_a_dout;
                b_bit     = w_b_dout;
                first     = (r_count == '0);
                last      = w_at_last;
            end
            default: begin
                in_ready = 1'b0;
            end
        endcase
    end

    // ------------------------------------------------------------------
    // Bit counter: index of the bit pair currently on the outputs.
    // Cleared on load and after the last transfer, so it never wraps.
    // ------------------------------------------------------------------
    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
        end else if (w_accept) begin
            r_count <= '0;
        end else if (w_xfer) begin
            if (w_at_last) begin
                r_count <= '0;
            end else begin
                r_count <= r_count + 1'b1;
            end
        end
    end

endmodule
